// File: rtl/level_meter_ctrl.sv
// rtl/level_meter_ctrl.sv - windowed in/out mean-square meter with shared log converter, gain in 0.1 dB
module level_meter_ctrl #(
  parameter int WIN_LOG2 = 13
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sample_valid,
  input  logic signed [15:0] in_wave,
  input  logic signed [15:0] out_wave,
  output logic               conv_req,
  output logic               conv_sel,
  output logic        [31:0] conv_arg,
  input  logic               conv_ack,
  input  logic signed [15:0] conv_result,
  input  logic               ovr_clr,
  output logic signed [15:0] db_level,
  output logic               db_valid,
  output logic               overrun
);

  typedef enum logic [1:0] {IDLE, REQ_IN, REQ_OUT, DONE} state_t;

  localparam logic [WIN_LOG2-1:0] CNT_MAX  = '1;
  localparam logic signed [15:0]  FLOOR_DB = -16'sd1000;

  state_t state_q, state_d;

  logic [WIN_LOG2-1:0] cnt;
  logic [47:0]         in_sum, out_sum;
  logic [31:0]         in_snap, out_snap;
  logic signed [15:0]  in_res;
  logic signed [15:0]  out_r;
  logic signed [16:0]  db_diff;
  logic signed [15:0]  db_sat;

  logic signed [31:0]  in_prod, out_prod;
  logic [47:0]         in_next, out_next;
  logic [47:0]         in_shift, out_shift;
  logic                win_close;
  logic                in_zero, out_zero;

  // Squares of full-scale negative samples are exactly 2**30, so 31 bits never overflow.
  assign in_prod   = in_wave * in_wave;
  assign out_prod  = out_wave * out_wave;
  assign in_next   = in_sum + {17'd0, in_prod[30:0]};
  assign out_next  = out_sum + {17'd0, out_prod[30:0]};
  assign in_shift  = in_next >> WIN_LOG2;
  assign out_shift = out_next >> WIN_LOG2;
  assign win_close = sample_valid && (cnt == CNT_MAX);
  assign in_zero   = (in_snap == 32'd0);
  assign out_zero  = (out_snap == 32'd0);

  // Output-channel result as seen in REQ_OUT; a zero operand substitutes the -100.0 dB floor.
  assign out_r   = out_zero ? FLOOR_DB : conv_result;
  assign db_diff = {out_r[15], out_r} - {in_res[15], in_res};

  // Clamp the 17-bit gain difference into the signed 16-bit range.
  always_comb begin
    db_sat = db_diff[15:0];
    if (db_diff > 17'sd32767) begin
      db_sat = 16'sh7FFF;
    end else if (db_diff < -17'sd32768) begin
      db_sat = 16'sh8000;
    end
  end

  // Sample accumulation and window counting; runs every sample regardless of FSM state.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      in_sum  <= '0;
      out_sum <= '0;
    end else if (sample_valid) begin
      cnt <= cnt + WIN_LOG2'(1);
      if (win_close) begin
        in_sum  <= '0;
        out_sum <= '0;
      end else begin
        in_sum  <= in_next;
        out_sum <= out_next;
      end
    end
  end

  // State register, snapshots, captured results, gain output and sticky overrun.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      in_snap  <= '0;
      out_snap <= '0;
      in_res   <= '0;
      db_level <= '0;
      db_valid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      state_q  <= state_d;
      db_valid <= 1'b0;
      if (win_close && state_q == IDLE) begin
        in_snap  <= in_shift[31:0];
        out_snap <= out_shift[31:0];
      end
      if (win_close && state_q != IDLE) begin
        overrun <= 1'b1;
      end else if (ovr_clr) begin
        overrun <= 1'b0;
      end
      if (state_q == REQ_IN) begin
        if (in_zero) begin
          in_res <= FLOOR_DB;
        end else if (conv_ack) begin
          in_res <= conv_result;
        end
      end
      // The gain register loads as REQ_OUT completes so db_valid and db_level align in DONE.
      if (state_q == REQ_OUT && (out_zero || conv_ack)) begin
        db_level <= db_sat;
        db_valid <= 1'b1;
      end
    end
  end

  // Next-state and converter handshake outputs.
  always_comb begin
    state_d  = state_q;
    conv_req = 1'b0;
    conv_sel = 1'b0;
    conv_arg = 32'd0;
    case (state_q)
      IDLE: begin
        if (win_close) state_d = REQ_IN;
      end
      REQ_IN: begin
        conv_arg = in_snap;
        conv_req = !in_zero;
        if (in_zero || conv_ack) state_d = REQ_OUT;
      end
      REQ_OUT: begin
        conv_sel = 1'b1;
        conv_arg = out_snap;
        conv_req = !out_zero;
        if (out_zero || conv_ack) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_level_meter_ctrl.sv
// tb/tb_level_meter_ctrl.sv - self-checking bench for level_meter_ctrl with WIN_LOG2=2
module tb_level_meter_ctrl;

  localparam int WL = 2;

  logic               clk = 1'b0;
  logic               reset;
  logic               sample_valid;
  logic signed [15:0] in_wave;
  logic signed [15:0] out_wave;
  logic               conv_req;
  logic               conv_sel;
  logic        [31:0] conv_arg;
  logic               conv_ack;
  logic signed [15:0] conv_result;
  logic               ovr_clr;
  logic signed [15:0] db_level;
  logic               db_valid;
  logic               overrun;

  int tests = 0;
  int fails = 0;

  level_meter_ctrl #(.WIN_LOG2(WL)) dut (
    .clk(clk), .reset(reset), .sample_valid(sample_valid),
    .in_wave(in_wave), .out_wave(out_wave),
    .conv_req(conv_req), .conv_sel(conv_sel), .conv_arg(conv_arg),
    .conv_ack(conv_ack), .conv_result(conv_result), .ovr_clr(ovr_clr),
    .db_level(db_level), .db_valid(db_valid), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected gain: zero operands use -1000, difference clamped to signed 16 bits.
  function automatic int exp_db(input longint ein, input longint eout, input int rin, input int rout);
    int fi, fo, d;
    fi = (ein == 0) ? -1000 : rin;
    fo = (eout == 0) ? -1000 : rout;
    d = fo - fi;
    if (d > 32767) d = 32767;
    if (d < -32768) d = -32768;
    return d;
  endfunction

  function automatic int rand_sample();
    int k;
    k = $urandom_range(0, 9);
    if (k == 0) return -32768;
    if (k == 1) return 32767;
    if (k == 2) return 0;
    return int'($signed(16'($urandom)));
  endfunction

  function automatic int rand_result();
    if ($urandom_range(0, 3) == 0) return int'($signed(16'($urandom)));
    return int'($urandom_range(0, 3000)) - 1500;
  endfunction

  // Drives one window of four samples; model returns mean-square operands.
  task automatic send_window(input int iv[4], input int ov[4], input bit gaps, input bit clr_last,
                             output longint ein, output longint eout);
    longint si, so;
    int g;
    si = 0;
    so = 0;
    for (int i = 0; i < 4; i++) begin
      if (gaps) begin
        g = $urandom_range(0, 2);
        repeat (g) tick();
      end
      sample_valid = 1'b1;
      in_wave      = 16'(iv[i]);
      out_wave     = 16'(ov[i]);
      ovr_clr      = clr_last && (i == 3);
      si += longint'(iv[i]) * longint'(iv[i]);
      so += longint'(ov[i]) * longint'(ov[i]);
      tick();
      sample_valid = 1'b0;
      ovr_clr      = 1'b0;
      in_wave      = 16'($urandom);
      out_wave     = 16'($urandom);
    end
    ein  = (si >> WL) & 64'hFFFF_FFFF;
    eout = (so >> WL) & 64'hFFFF_FFFF;
  endtask

  // Plays the converter from the first REQ_IN cycle through the DONE cycle and one hold cycle.
  task automatic convert(input string tag, input longint ein, input longint eout,
                         input int rin, input int rout, input int din, input int dout);
    longint a;
    int r, dl, e;
    e = exp_db(ein, eout, rin, rout);
    for (int ch = 0; ch < 2; ch++) begin
      a  = (ch == 1) ? eout : ein;
      r  = (ch == 1) ? rout : rin;
      dl = (ch == 1) ? dout : din;
      if (a == 0) begin
        tests++;
        if (conv_req !== 1'b0) begin
          fails++;
          $display("FAIL %s zero_op ch%0d: conv_req=%b required 0", tag, ch, conv_req);
        end
        conv_ack    = 1'b1;
        conv_result = 16'($urandom);
        tick();
        conv_ack = 1'b0;
      end else begin
        for (int d = 0; d <= dl; d++) begin
          tests++;
          if (conv_req !== 1'b1 || conv_sel !== ch[0] || conv_arg !== a[31:0]) begin
            fails++;
            $display("FAIL %s req ch%0d cyc%0d: req=%b sel=%b arg=%0d required req=1 sel=%0d arg=%0d",
                     tag, ch, d, conv_req, conv_sel, conv_arg, ch, a[31:0]);
          end
          if (d == dl) begin
            conv_ack    = 1'b1;
            conv_result = 16'(r);
          end
          tick();
        end
        conv_ack    = 1'b0;
        conv_result = 16'($urandom);
      end
    end
    tests++;
    if (db_valid !== 1'b1 || db_level !== 16'(e)) begin
      fails++;
      $display("FAIL %s db: valid=%b level=%0d required valid=1 level=%0d", tag, db_valid, db_level, e);
    end
    tick();
    tests++;
    if (db_valid !== 1'b0 || db_level !== 16'(e) || conv_req !== 1'b0) begin
      fails++;
      $display("FAIL %s db_hold: valid=%b level=%0d req=%b required valid=0 level=%0d req=0",
               tag, db_valid, db_level, conv_req, e);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; sample_valid = 1'b1; in_wave = 16'sd1234; out_wave = -16'sd77;
    conv_ack = 1'b1; conv_result = 16'sd5; ovr_clr = 1'b0;
    tick();
    tick();
    tests++;
    if (conv_req !== 1'b0 || conv_sel !== 1'b0 || conv_arg !== 32'd0 ||
        db_level !== 16'sd0 || db_valid !== 1'b0 || overrun !== 1'b0) begin
      fails++;
      $display("FAIL reset: req=%b sel=%b arg=%0d level=%0d valid=%b ovr=%b required all 0",
               conv_req, conv_sel, conv_arg, db_level, db_valid, overrun);
    end
    reset = 1'b0; sample_valid = 1'b0; conv_ack = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    longint ein, eout;
    send_window('{1000, 1000, 1000, 1000}, '{2000, 2000, 2000, 2000}, 1'b0, 1'b0, ein, eout);
    convert("basic", ein, eout, 600, 660, 0, 0);
  endtask

  task automatic test_zero_in();
    longint ein, eout;
    send_window('{0, 0, 0, 0}, '{100, 100, 100, 100}, 1'b0, 1'b0, ein, eout);
    convert("zero_in", ein, eout, 0, 400, 0, 0);
  endtask

  task automatic test_full_scale();
    longint ein, eout;
    send_window('{-32768, -32768, -32768, -32768}, '{-32768, -32768, -32768, -32768}, 1'b0, 1'b0, ein, eout);
    convert("full_scale", ein, eout, 900, 850, 1, 2);
  endtask

  task automatic test_saturation();
    longint ein, eout;
    send_window('{1000, 1000, 1000, 1000}, '{2000, 2000, 2000, 2000}, 1'b0, 1'b0, ein, eout);
    convert("sat_hi", ein, eout, -30000, 30000, 0, 0);
    send_window('{1000, 1000, 1000, 1000}, '{2000, 2000, 2000, 2000}, 1'b0, 1'b0, ein, eout);
    convert("sat_lo", ein, eout, 30000, -30000, 0, 0);
  endtask

  task automatic test_overrun();
    longint ea_in, ea_out, eb_in, eb_out;
    int iv[4], ov[4];
    send_window('{1000, 1000, 1000, 1000}, '{2000, 2000, 2000, 2000}, 1'b0, 1'b0, ea_in, ea_out);
    for (int i = 0; i < 4; i++) begin iv[i] = rand_sample(); ov[i] = rand_sample(); end
    send_window(iv, ov, 1'b0, 1'b0, eb_in, eb_out);
    tests++;
    if (overrun !== 1'b1 || conv_req !== 1'b1 || conv_arg !== ea_in[31:0]) begin
      fails++;
      $display("FAIL overrun_set: ovr=%b req=%b arg=%0d required ovr=1 req=1 arg=%0d",
               overrun, conv_req, conv_arg, ea_in[31:0]);
    end
    convert("overrun_first", ea_in, ea_out, 600, 660, 0, 0);
    tests++;
    if (overrun !== 1'b1) begin
      fails++;
      $display("FAIL overrun_sticky: ovr=%b required 1", overrun);
    end
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    tests++;
    if (overrun !== 1'b0) begin
      fails++;
      $display("FAIL ovr_clr: ovr=%b required 0", overrun);
    end
    for (int i = 0; i < 4; i++) begin iv[i] = rand_sample(); ov[i] = rand_sample(); end
    send_window(iv, ov, 1'b1, 1'b0, ea_in, ea_out);
    convert("after_drop", ea_in, ea_out, rand_result(), rand_result(), 0, 1);
    send_window('{300, -300, 300, -300}, '{50, 60, 70, 80}, 1'b0, 1'b0, ea_in, ea_out);
    send_window(iv, ov, 1'b0, 1'b1, eb_in, eb_out);
    tests++;
    if (overrun !== 1'b1) begin
      fails++;
      $display("FAIL ovr_set_wins: ovr=%b required 1", overrun);
    end
    convert("set_wins", ea_in, ea_out, 100, 200, 0, 0);
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
  endtask

  task automatic test_reset_mid();
    longint ein, eout;
    send_window('{1000, 1000, 1000, 1000}, '{2000, 2000, 2000, 2000}, 1'b0, 1'b0, ein, eout);
    conv_ack = 1'b1; conv_result = 16'sd500; sample_valid = 1'b1; in_wave = 16'sd9000; out_wave = 16'sd9000;
    tick();
    tests++;
    if (conv_req !== 1'b1 || conv_sel !== 1'b1) begin
      fails++;
      $display("FAIL pre_reset_req_out: req=%b sel=%b required req=1 sel=1", conv_req, conv_sel);
    end
    conv_ack = 1'b0; reset = 1'b1;
    tick();
    tests++;
    if (conv_req !== 1'b0 || db_valid !== 1'b0 || db_level !== 16'sd0 || conv_arg !== 32'd0) begin
      fails++;
      $display("FAIL reset_mid: req=%b valid=%b level=%0d arg=%0d required 0 0 0 0",
               conv_req, db_valid, db_level, conv_arg);
    end
    reset = 1'b0; sample_valid = 1'b0; conv_ack = 1'b1; conv_result = 16'sd123;
    tick();
    conv_ack = 1'b0;
    tests++;
    if (conv_req !== 1'b0 || db_valid !== 1'b0) begin
      fails++;
      $display("FAIL ack_after_reset: req=%b valid=%b required 0 0", conv_req, db_valid);
    end
    tick();
    tests++;
    if (db_valid !== 1'b0 || db_level !== 16'sd0) begin
      fails++;
      $display("FAIL ack_after_reset_hold: valid=%b level=%0d required 0 0", db_valid, db_level);
    end
    send_window('{1000, 1000, 1000, 1000}, '{2000, 2000, 2000, 2000}, 1'b0, 1'b0, ein, eout);
    convert("post_reset", ein, eout, 600, 660, 0, 0);
  endtask

  task automatic test_random();
    longint ein, eout;
    int iv[4], ov[4];
    int mode;
    for (int n = 0; n < 25; n++) begin
      mode = $urandom_range(0, 7);
      for (int i = 0; i < 4; i++) begin
        iv[i] = (mode == 0) ? 0 : rand_sample();
        ov[i] = (mode == 1) ? 0 : rand_sample();
      end
      send_window(iv, ov, 1'b1, 1'b0, ein, eout);
      convert("random", ein, eout, rand_result(), rand_result(),
              $urandom_range(0, 3), $urandom_range(0, 3));
      repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_zero_in();
    test_full_scale();
    test_saturation();
    test_overrun();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
